// File: rtl/alu_reg_datapath.sv
// rtl/alu_reg_datapath.sv - 8-bit accumulator/register bank slice with combinational ALU (optional flags: ALU_FLAGS_EN)
module alu_reg_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             acc_sel,
  input  logic [2:0]       source_sel,
  input  logic [3:0]       destination_sel,
  input  logic [1:0]       alu_b_sel,
  input  logic [1:0]       bank_out_sel,
  input  logic [2:0]       operation_select,
  input  logic [WIDTH-1:0] bank_data_in,
`ifdef ALU_FLAGS_EN
  output logic             zero_flag,
  output logic             carry_flag,
`endif
  output logic [WIDTH-1:0] bank_data_out,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [WIDTH-1:0] alu_out
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] r0_q;
  logic [WIDTH-1:0] r1_q;
  logic [WIDTH-1:0] r2_q;
  logic [WIDTH-1:0] source_data;

  // Source mux feeding register writes; unused codes yield zero so they can clear a register.
  always_comb begin
    source_data = '0;
    case (source_sel)
      3'b000:  source_data = acc_q;
      3'b001:  source_data = r0_q;
      3'b010:  source_data = r1_q;
      3'b011:  source_data = r2_q;
      3'b100:  source_data = bank_data_in;
      default: source_data = '0;
    endcase
  end

  // Operand B mux: immediate or one of the general registers.
  always_comb begin
    alu_b = bank_data_in;
    case (alu_b_sel)
      2'b00: alu_b = bank_data_in;
      2'b01: alu_b = r0_q;
      2'b10: alu_b = r1_q;
      2'b11: alu_b = r2_q;
    endcase
  end

  // Observation mux for the register bank.
  always_comb begin
    bank_data_out = acc_q;
    case (bank_out_sel)
      2'b00: bank_data_out = acc_q;
      2'b01: bank_data_out = r0_q;
      2'b10: bank_data_out = r1_q;
      2'b11: bank_data_out = r2_q;
    endcase
  end

  assign alu_a = acc_q;

  // ALU: results wrap to WIDTH bits, shifts are zero-filling.
  always_comb begin
    alu_out = '0;
    case (operation_select)
      OP_ADD: alu_out = alu_a + alu_b;
      OP_SUB: alu_out = alu_a - alu_b;
      OP_AND: alu_out = alu_a & alu_b;
      OP_OR:  alu_out = alu_a | alu_b;
      OP_XOR: alu_out = alu_a ^ alu_b;
      OP_NOT: alu_out = ~alu_a;
      OP_SHL: alu_out = {alu_a[WIDTH-2:0], 1'b0};
      OP_SHR: alu_out = {1'b0, alu_a[WIDTH-1:1]};
    endcase
  end

`ifdef ALU_FLAGS_EN
  logic [WIDTH:0] add_wide;
  logic [WIDTH:0] sub_wide;

  assign add_wide = {1'b0, alu_a} + {1'b0, alu_b};
  // Top bit of the extended difference is set exactly when A < B unsigned (borrow).
  assign sub_wide = {1'b0, alu_a} - {1'b0, alu_b};

  // Flags track the current operands; nothing here is registered.
  always_comb begin
    zero_flag  = (alu_out == '0);
    carry_flag = 1'b0;
    case (operation_select)
      OP_ADD:  carry_flag = add_wide[WIDTH];
      OP_SUB:  carry_flag = sub_wide[WIDTH];
      OP_SHL:  carry_flag = alu_a[WIDTH-1];
      OP_SHR:  carry_flag = alu_a[0];
      default: carry_flag = 1'b0;
    endcase
  end
`endif

  // Register bank: every selected destination writes on the same edge from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      r0_q  <= '0;
      r1_q  <= '0;
      r2_q  <= '0;
    end else begin
      if (destination_sel[0]) acc_q <= acc_sel ? source_data : alu_out;
      if (destination_sel[1]) r0_q  <= source_data;
      if (destination_sel[2]) r1_q  <= source_data;
      if (destination_sel[3]) r2_q  <= source_data;
    end
  end

endmodule

// File: tb/tb_alu_reg_datapath.sv
// tb/tb_alu_reg_datapath.sv - scoreboard bench for alu_reg_datapath
module tb_alu_reg_datapath;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       acc_sel = 1'b0;
  logic [2:0] source_sel = 3'b000;
  logic [3:0] destination_sel = 4'b0000;
  logic [1:0] alu_b_sel = 2'b00;
  logic [1:0] bank_out_sel = 2'b00;
  logic [2:0] operation_select = 3'b000;
  logic [7:0] bank_data_in = 8'h00;
  logic [7:0] bank_data_out;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_out;
`ifdef ALU_FLAGS_EN
  logic       zero_flag;
  logic       carry_flag;
`endif

  alu_reg_datapath #(.WIDTH(8)) dut (
    .clk(clk),
    .reset(reset),
    .acc_sel(acc_sel),
    .source_sel(source_sel),
    .destination_sel(destination_sel),
    .alu_b_sel(alu_b_sel),
    .bank_out_sel(bank_out_sel),
    .operation_select(operation_select),
    .bank_data_in(bank_data_in),
`ifdef ALU_FLAGS_EN
    .zero_flag(zero_flag),
    .carry_flag(carry_flag),
`endif
    .bank_data_out(bank_data_out),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_out(alu_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    logic [7:0] value;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;
  int   checks = 0;
  int   failures = 0;

  function automatic logic [7:0] observe(int kind);
    logic [7:0] v;
    v = 8'h00;
    case (kind)
      0: v = bank_data_out;
      1: v = alu_out;
      2: v = alu_b;
      3: v = alu_a;
`ifdef ALU_FLAGS_EN
      4: v = {7'b0, zero_flag};
      5: v = {7'b0, carry_flag};
`endif
      default: v = 8'hxx;
    endcase
    return v;
  endfunction

  // Monitor: drains the scoreboard each time the DUT outputs are declared settled.
  initial begin
    forever begin
      @(sample_ev);
      while (exp_q.size() > 0) begin
        exp_t e;
        logic [7:0] got;
        e = exp_q.pop_front();
        got = observe(e.kind);
        checks++;
        if (got !== e.value) begin
          failures++;
          $display("FAIL %s: got %02h expected %02h", e.name, got, e.value);
        end
      end
    end
  end

  task automatic expect_val(input int kind, input logic [7:0] value, input string name);
    exp_t e;
    e.kind = kind;
    e.value = value;
    e.name = name;
    exp_q.push_back(e);
    #1;
    -> sample_ev;
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s: monitor did not consume entry, got pending=%0d expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic expect_reg(input logic [1:0] sel, input logic [7:0] value, input string name);
    bank_out_sel = sel;
    expect_val(0, value, name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    destination_sel = 4'b0000;
  endtask

  task automatic load_acc(input logic [7:0] v);
    bank_data_in = v;
    source_sel = 3'b100;
    acc_sel = 1'b1;
    destination_sel = 4'b0001;
    step();
  endtask

  logic [7:0] op_exp [8];
  logic       op_cf  [8];

  initial begin
    op_exp = '{8'hD2, 8'h5A, 8'h14, 8'hBE, 8'hAA, 8'h69, 8'h2C, 8'h4B};
    op_cf  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset state
    bank_data_in = 8'h33;
    alu_b_sel = 2'b00;
    expect_reg(2'b00, 8'h00, "reset_acc");
    expect_val(3, 8'h00, "reset_alu_a");
    expect_val(2, 8'h33, "reset_alu_b_imm");
    expect_val(1, 8'h33, "reset_alu_out");
    alu_b_sel = 2'b01;
    expect_val(2, 8'h00, "reset_alu_b_r0");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Load and add
    load_acc(8'hAA);
    expect_reg(2'b00, 8'hAA, "load_acc_aa");
    bank_data_in = 8'h55;
    destination_sel = 4'b0010;
    step();
    expect_reg(2'b01, 8'h55, "load_r0_55");
    alu_b_sel = 2'b01;
    operation_select = 3'b000;
    acc_sel = 1'b0;
    destination_sel = 4'b0001;
    expect_val(1, 8'hFF, "add_pre_edge");
    step();
    expect_reg(2'b00, 8'hFF, "add_acc_ff");

    // Hold with changing immediate
    source_sel = 3'b100;
    acc_sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bank_data_in = 8'h10 + 8'(i * 37);
      step();
    end
    expect_reg(2'b00, 8'hFF, "hold_acc");
    expect_reg(2'b01, 8'h55, "hold_r0");
    expect_reg(2'b10, 8'h00, "hold_r1");

    // Wrap on add
    alu_b_sel = 2'b00;
    bank_data_in = 8'h01;
    operation_select = 3'b000;
    acc_sel = 1'b0;
    destination_sel = 4'b0001;
    expect_val(1, 8'h00, "wrap_add_out");
`ifdef ALU_FLAGS_EN
    expect_val(4, 8'h01, "wrap_add_zf");
    expect_val(5, 8'h01, "wrap_add_cf");
`endif
    step();
    expect_reg(2'b00, 8'h00, "wrap_add_acc");

    // Wrap on subtract
    operation_select = 3'b001;
    acc_sel = 1'b0;
    destination_sel = 4'b0001;
    expect_val(1, 8'hFF, "wrap_sub_out");
`ifdef ALU_FLAGS_EN
    expect_val(5, 8'h01, "wrap_sub_borrow");
`endif
    step();
    expect_reg(2'b00, 8'hFF, "wrap_sub_acc");

    // All opcodes with ACC=96, B=3C
    load_acc(8'h96);
    alu_b_sel = 2'b00;
    bank_data_in = 8'h3C;
    for (int op = 0; op < 8; op++) begin
      operation_select = 3'(op);
      expect_val(1, op_exp[op], $sformatf("op%0d_out", op));
`ifdef ALU_FLAGS_EN
      expect_val(5, {7'b0, op_cf[op]}, $sformatf("op%0d_cf", op));
      expect_val(4, 8'h00, $sformatf("op%0d_zf", op));
`endif
    end

    // Shift boundaries
    load_acc(8'h80);
    operation_select = 3'b110;
    expect_val(1, 8'h00, "shl_80");
    load_acc(8'h01);
    operation_select = 3'b111;
    expect_val(1, 8'h00, "shr_01");

    // Multi-write broadcast of ACC
    load_acc(8'h5A);
    source_sel = 3'b000;
    destination_sel = 4'b1110;
    step();
    expect_reg(2'b01, 8'h5A, "bcast_r0");
    expect_reg(2'b10, 8'h5A, "bcast_r1");
    expect_reg(2'b11, 8'h5A, "bcast_r2");

    // ACC from R2
    load_acc(8'h11);
    source_sel = 3'b011;
    acc_sel = 1'b1;
    destination_sel = 4'b0001;
    step();
    expect_reg(2'b00, 8'h5A, "acc_from_r2");

    // Unused source codes clear destinations
    source_sel = 3'b101;
    destination_sel = 4'b0100;
    step();
    expect_reg(2'b10, 8'h00, "src101_r1");
    source_sel = 3'b111;
    acc_sel = 1'b1;
    destination_sel = 4'b0001;
    step();
    expect_reg(2'b00, 8'h00, "src111_acc");

    // Same-edge read-before-write: ACC <= ~ACC while R0 <= old ACC
    load_acc(8'h3C);
    source_sel = 3'b000;
    acc_sel = 1'b0;
    operation_select = 3'b101;
    destination_sel = 4'b0011;
    step();
    expect_reg(2'b00, 8'hC3, "rbw_acc");
    expect_reg(2'b01, 8'h3C, "rbw_r0");

    // Asynchronous reset mid-cycle
    #2;
    reset = 1'b1;
    expect_reg(2'b00, 8'h00, "areset_acc");
    expect_reg(2'b01, 8'h00, "areset_r0");
    expect_reg(2'b10, 8'h00, "areset_r1");
    expect_reg(2'b11, 8'h00, "areset_r2");

    #10;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
